fetch_unit: RTL

//  Parametrised instruction-fetch front end; next generation of the pc/PC_add4/imem path.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word requests to a variable-latency
// instruction memory, buffers in-order responses in a small FIFO and presents
// {inst, pc, pc+4} to decode. Redirects flush the FIFO and discard in-flight responses.
module fetch_unit #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic            fetch_err_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   rsp_pc;
    logic [XLEN-1:0]   fifo_inst [DEPTH];
    logic [XLEN-1:0]   fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  discard;

    logic [SUM_W-1:0]  credit_used;
    logic              grant;
    logic              rsp_take;
    logic              rsp_drop;
    logic              pop;
    logic              misaligned;

    // Credit accounting, handshake qualifiers and the combinational head view
    always_comb begin
        credit_used  = SUM_W'(count) + SUM_W'(inflight) + SUM_W'(discard);
        misaligned   = (redirect_pc_i[1:0] != 2'b00);
        imem_req_o   = (state == RUN) && !redirect_i && (credit_used < SUM_W'(DEPTH));
        imem_addr_o  = fetch_pc;
        grant        = imem_req_o && imem_gnt_i;
        rsp_drop     = imem_rvalid_i && (discard != '0);
        rsp_take     = imem_rvalid_i && (discard == '0) && !redirect_i;
        inst_valid_o = (count != '0);
        pop          = inst_valid_o && inst_ready_i && !redirect_i;
        inst_o       = fifo_inst[rd_ptr];
        pc_o         = fifo_pc[rd_ptr];
        pc4_o        = fifo_pc[rd_ptr] + XLEN'(4);
    end

    // Control FSM and sticky misaligned-redirect flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= BOOT;
            fetch_err_o <= 1'b0;
        end else begin
            if (redirect_i) begin
                fetch_err_o <= misaligned;
            end
            case (state)
                BOOT: state <= (redirect_i && misaligned) ? ERR : RUN;
                RUN: begin
                    if (redirect_i && misaligned) state <= ERR;
                    else if (halt_i)              state <= HALT;
                end
                HALT: begin
                    if (redirect_i && misaligned) state <= ERR;
                    else if (!halt_i)             state <= RUN;
                end
                ERR: begin
                    if (redirect_i && !misaligned) state <= RUN;
                end
                default: state <= BOOT;
            endcase
        end
    end

    // PCs, FIFO pointers and outstanding-request counters; redirect flushes everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
            rsp_pc   <= redirect_pc_i;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            // every response still owed (minus the one dropped this cycle) must be discarded
            discard  <= discard + inflight - CNT_W'(imem_rvalid_i);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (rsp_take) begin
                rsp_pc <= rsp_pc + XLEN'(4);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            discard  <= discard - CNT_W'(rsp_drop);
            inflight <= inflight + CNT_W'(grant) - CNT_W'(rsp_take);
            count    <= count + CNT_W'(rsp_take) - CNT_W'(pop);
        end
    end

    // FIFO storage, written with the response word and the PC it belongs to
    always_ff @(posedge clk_i) begin
        if (rsp_take) begin
            fifo_inst[wr_ptr] <= imem_rdata_i;
            fifo_pc[wr_ptr]   <= rsp_pc;
        end
    end

    // A response with nothing outstanding means the memory broke the protocol
    always_ff @(posedge clk_i) begin
        if (!rst_i && imem_rvalid_i) begin
            rvalid_outstanding: assert ((inflight != '0) || (discard != '0));
        end
    end

endmodule
